imem_bundle_loader: RTL and testbench

// Writer side of the instruction-memory bundle interface. Accepts a stream of 32-bit slot

---
 rtl/imem_bundle_loader.sv | 122 ++++++++++++
 tb/tb_imem_bundle_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_bundle_loader.sv
// Packs a stream of slot instructions into VLIW bundles and writes them to
// instruction memory at consecutive addresses starting from a latched base.
module imem_bundle_loader #(
  parameter int unsigned         SLOTS    = 6,
  parameter int unsigned         WORD_W   = 32,
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [WORD_W-1:0]   NOP_WORD = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           bundle_count,
  input  logic                      in_valid,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      imem_we,
  output logic [ADDR_W-1:0]         imem_addr,
  output logic [SLOTS*WORD_W-1:0]   imem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      short_load
);

  localparam int unsigned CNT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t               state, next_state;
  logic [WORD_W-1:0]    slots [SLOTS];
  logic [CNT_W-1:0]     slot_cnt;
  logic [ADDR_W-1:0]    cur_addr;
  logic [ADDR_W:0]      count;
  logic [ADDR_W:0]      written;
  logic [ADDR_W:0]      written_inc;
  logic                 final_q;
  logic                 accept;
  logic                 bundle_end;
  logic [SLOTS*WORD_W-1:0] next_bundle;

  assign in_ready = (state == COLLECT);
  assign imem_we  = (state == WRITE);
  assign busy     = (state == COLLECT) || (state == WRITE);
  assign done     = (state == DONE);

  always_comb begin
    accept      = (state == COLLECT) && in_valid;
    bundle_end  = accept && ((slot_cnt == CNT_W'(SLOTS - 1)) || in_last);
    written_inc = written + 1'b1;

    // Bundle as it stands once the current word lands: earlier slots from
    // storage, the current slot from in_data, later slots NOP-filled.
    next_bundle = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (i < 32'(slot_cnt))
        next_bundle[i*WORD_W +: WORD_W] = slots[i];
      else if (i == 32'(slot_cnt))
        next_bundle[i*WORD_W +: WORD_W] = in_data;
      else
        next_bundle[i*WORD_W +: WORD_W] = NOP_WORD;
    end

    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (bundle_end) next_state = WRITE;
      WRITE:   next_state = (final_q || written_inc == count) ? DONE : COLLECT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      cur_addr   <= '0;
      count      <= '0;
      written    <= '0;
      final_q    <= 1'b0;
      short_load <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) slots[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= base_addr;
            count      <= (bundle_count == '0) ? {1'b1, {ADDR_W{1'b0}}} : bundle_count;
            written    <= '0;
            final_q    <= 1'b0;
            short_load <= 1'b0;
            slot_cnt   <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            slots[slot_cnt] <= in_data;
            slot_cnt        <= slot_cnt + 1'b1;
          end
          // Write port registers load here so they hold steady between strobes.
          if (bundle_end) begin
            imem_addr  <= cur_addr;
            imem_wdata <= next_bundle;
            final_q    <= in_last;
          end
        end
        WRITE: begin
          cur_addr <= cur_addr + 1'b1;
          written  <= written_inc;
          slot_cnt <= '0;
          if (final_q && (written_inc < count)) short_load <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_bundle_loader.sv
// Scoreboard bench for imem_bundle_loader: the driver queues expected writes,
// a negedge monitor checks every write strobe and done pulse against them.
module tb_imem_bundle_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   base_addr;
  logic [8:0]   bundle_count;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_ready;
  logic         imem_we;
  logic [7:0]   imem_addr;
  logic [191:0] imem_wdata;
  logic         busy;
  logic         done;
  logic         short_load;

  imem_bundle_loader #(.SLOTS(6), .WORD_W(32), .ADDR_W(8), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bundle_count(bundle_count), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .short_load(short_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   addr;
    logic [191:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  logic exp_sl[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic last_acc    = 1'b0;
  logic last_we     = 1'b0;

  task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  function automatic logic [191:0] pk(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {w5, w4, w3, w2, w1, w0};
  endfunction

  task automatic push_wr(input logic [7:0] a, input logic [191:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      last_acc = 1'b0;
      last_we  = 1'b0;
    end else begin
      if (imem_we) begin
        if (exp_wr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_we: got write at %h, expected none", imem_addr);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check_vec("we_addr", 192'(imem_addr), 192'(e.addr));
          check_vec("we_data", imem_wdata, e.data);
          check_bit("we_latency", last_acc, 1'b1);
          check_bit("we_busy", busy, 1'b1);
        end
      end
      if (done) begin
        check_bit("done_after_we", last_we, 1'b1);
        check_bit("done_busy", busy, 1'b0);
        if (exp_sl.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done, expected none");
        end else begin
          check_bit("short_load", short_load, exp_sl.pop_front());
        end
      end
      last_acc = in_valid && in_ready;
      last_we  = imem_we;
    end
  end

  task automatic do_start(input logic [7:0] b, input logic [8:0] c);
    start = 1'b1;
    base_addr = b;
    bundle_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int stall);
    bit got = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got in_ready=0 for 50 cycles, expected 1 (word %h)", d);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit poke_start);
    bit got = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in 4000 cycles, expected done");
    end
    if (poke_start) begin
      start = 1'b1;
      base_addr = 8'hAA;
      bundle_count = 9'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; bundle_count = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_vec("reset_flags", 192'({in_ready, imem_we, busy, done, short_load}), '0);
    check_vec("reset_data", imem_wdata | 192'(imem_addr), '0);
    @(posedge clk); #1;

    // 1: two full bundles, no stalls
    push_wr(8'h10, pk(32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106));
    push_wr(8'h11, pk(32'h107, 32'h108, 32'h109, 32'h10A, 32'h10B, 32'h10C));
    exp_sl.push_back(1'b0);
    do_start(8'h10, 9'd2);
    for (int i = 0; i < 12; i++) send_word(32'h101 + 32'(i), 1'b0, 0);
    wait_done(1'b0);

    // 2: in_last in slot1 of bundle 1 ends a count=4 load early
    push_wr(8'h00, pk(32'h201, 32'h202, 32'h203, 32'h204, 32'h205, 32'h206));
    push_wr(8'h01, pk(32'h207, 32'h208, 32'h0, 32'h0, 32'h0, 32'h0));
    exp_sl.push_back(1'b1);
    do_start(8'h00, 9'd4);
    for (int i = 0; i < 8; i++) send_word(32'h201 + 32'(i), (i == 7), 0);
    wait_done(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("short_load_sticky", short_load, 1'b1);
    @(posedge clk); #1;

    // 3: stalled input, short_load cleared by the new start
    push_wr(8'h40, pk(32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306));
    exp_sl.push_back(1'b0);
    do_start(8'h40, 9'd1);
    @(negedge clk);
    check_bit("short_load_cleared", short_load, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send_word(32'h301 + 32'(i), 1'b0, (i % 2 == 1) ? 2 : 0);
    wait_done(1'b0);

    // 4a: address wrap FF -> 00
    push_wr(8'hFF, pk(32'h401, 32'h402, 32'h403, 32'h404, 32'h405, 32'h406));
    push_wr(8'h00, pk(32'h407, 32'h408, 32'h409, 32'h40A, 32'h40B, 32'h40C));
    exp_sl.push_back(1'b0);
    do_start(8'hFF, 9'd2);
    for (int i = 0; i < 12; i++) send_word(32'h401 + 32'(i), 1'b0, 0);
    wait_done(1'b0);

    // 4b: count 0 means 256 bundles
    for (int j = 0; j < 256; j++) begin
      logic [31:0] w0;
      w0 = 32'h5000_0000 + 32'(j * 6);
      push_wr(8'(8'h80 + j), pk(w0, w0 + 1, w0 + 2, w0 + 3, w0 + 4, w0 + 5));
    end
    exp_sl.push_back(1'b0);
    do_start(8'h80, 9'd0);
    for (int k = 0; k < 256 * 6; k++) send_word(32'h5000_0000 + 32'(k), 1'b0, 0);
    wait_done(1'b0);

    // 5: reset after 3 words, then a clean load
    do_start(8'h20, 9'd2);
    for (int i = 0; i < 3; i++) send_word(32'h501 + 32'(i), 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_vec("midload_reset_flags", 192'({in_ready, imem_we, busy, done, short_load}), '0);
    check_vec("midload_reset_data", imem_wdata | 192'(imem_addr), '0);
    rst = 1'b0;
    push_wr(8'h30, pk(32'h601, 32'h602, 32'h603, 32'h604, 32'h605, 32'h606));
    exp_sl.push_back(1'b0);
    do_start(8'h30, 9'd1);
    for (int i = 0; i < 6; i++) send_word(32'h601 + 32'(i), 1'b0, 0);
    wait_done(1'b0);

    // 6: start during COLLECT and during done is ignored; no accepts afterwards
    push_wr(8'h50, pk(32'h701, 32'h702, 32'h703, 32'h704, 32'h705, 32'h706));
    push_wr(8'h51, pk(32'h707, 32'h708, 32'h709, 32'h70A, 32'h70B, 32'h70C));
    exp_sl.push_back(1'b0);
    do_start(8'h50, 9'd2);
    send_word(32'h701, 1'b0, 0);
    send_word(32'h702, 1'b0, 0);
    start = 1'b1;
    base_addr = 8'h99;
    send_word(32'h703, 1'b0, 0);
    start = 1'b0;
    for (int i = 3; i < 12; i++) send_word(32'h701 + 32'(i), 1'b0, 0);
    wait_done(1'b1);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      check_bit("ready_after_done", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    check_vec("pending_writes", 192'(exp_wr.size()), '0);
    check_vec("pending_dones", 192'(exp_sl.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
